fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC, drives the fetch address to the external instruction ROM, and captures the fetched instruction into the D-stage register.
- Computes the next PC from the redirect select produced in D (branch, j/jal, jr/bgezalr).
- Obeys PC_En/IF_ID_En from the hazard stall unit.
- Architectural delay slot: redirects never flush IF.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and base of instruction ROM.
- IM_WORDS, 1024, ROM depth in words; legal fetch range is [PC_RESET, PC_RESET+4*IM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PC_En  in  1  from stall unit; 0 holds PC.
- IF_ID_En  in  1  from stall unit; 0 holds IR_D/PC_D/AdEL_D.
- Instr_F  in  32  ROM read data for PC_F (combinational ROM).
- NPC_Sel  in  2  from D-stage control: 00 seq, 01 branch, 10 j/jal, 11 register.
- Br_Taken  in  1  D-stage comparator result; only used when NPC_Sel=01.
- Jr_Data  in  32  forwarded rs value for jr/bgezalr.
- PC_F  out  32  current fetch address to ROM.
- IR_D  out  32  instruction in D.
- PC_D  out  32  address of instruction in D.
- PC8_D  out  32  PC_D+8, link value for jal/bgezalr.
- AdEL_D  out  1  instruction in D came from an illegal fetch address.

Behaviour:
- Reset (reset=0, async): PC_F=PC_RESET, IR_D=0 (nop), PC_D=0, AdEL_D=0. PC8_D then reads 8.
- Registers update only on rising clk when reset=1.
- Next-PC, all 32-bit arithmetic with wrap-around, no overflow detect:
  - seq: PC_F+4.
  - branch: if Br_Taken, PC_D+4+(sext(IR_D[15:0])<<2); else PC_F+4.
  - j/jal: {PC_D[31:28], IR_D[25:0], 2'b00}.
  - register: Jr_Data, unaligned value passed through unchanged.
- Redirect targets use PC_D/IR_D, never PC_F. The delay-slot instruction already in IF proceeds normally.
- PC_En=0: PC_F holds, whatever NPC_Sel is. The redirecting instruction stays in D and re-asserts next cycle.
- IF_ID_En=1: IR_D<=legal?Instr_F:0, PC_D<=PC_F, AdEL_D<=!legal.
- IF_ID_En=0: IR_D, PC_D, AdEL_D hold.
- The two enables are honoured independently. The stall unit drives them together, but the block does not rely on that.
- legal = (PC_F[1:0]==0) and PC_RESET <= PC_F < PC_RESET+4*IM_WORDS, compared unsigned at 32 bits with no truncation.
- Illegal fetch inserts a nop with AdEL_D=1. The PC still advances per normal rules; there is no trap here.
- Reset mid-stall or mid-redirect: reset wins unconditionally. The first fetch after release is PC_RESET.
- PC8_D is combinational from PC_D, so it is never stale.
- Latency: instruction visible on IR_D one cycle after its address is on PC_F, absent stalls.

Decomposition:
- Shared package (mips_defs): NPC_SEL_SEQ/BR/J/REG encodings, NOP constant, PC_RESET default, opcode field ranges (op, rs, rt, rd, func, imm16, index26) shared with the stall unit and decoder.
- One sub-module: npc_calc, combinational next-PC mux and target adders. PC and IF/ID registers stay in fetch_stage.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> PC_F=0x3000, IR_D=0, AdEL_D=0; after 2 enabled cycles PC_F=0x3008, PC_D=0x3004.
- Sequential plus stall: enables high to PC_F=0x3010, then PC_En=IF_ID_En=0 for 2 cycles -> PC_F stays 0x3010, IR_D/PC_D frozen at 0x300C values; resume -> 0x3014 next.
- Taken beq with delay slot: IR_D=beq imm=0xFFFE at PC_D=0x3020, Br_Taken=1, NPC_Sel=01 -> next PC_F=0x301C, and the delay slot at 0x3024 still enters D.
- Not-taken beq: same setup with Br_Taken=0 -> next PC_F is PC_F+4.
- jal and jr: jal index=0x0000C10 at PC_D=0x3000 -> next PC_F=0x3040, PC8_D=0x3008. Then NPC_Sel=11, Jr_Data=0x3008 -> next PC_F=0x3008.
- Illegal fetch: Jr_Data=0x3002 redirect -> next cycle IR_D=0, AdEL_D=1. Separately PC_F=0x4000 with IM_WORDS=1024 -> AdEL_D=1.
- Async reset during stall: pulse reset low mid-cycle -> PC_F=0x3000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, nop, reset PC, instruction fields.
// Latency: n/a (constants, types and one pure function).
// Backpressure: n/a.
package mips_defs;

    // Redirect select produced by the D-stage decoder.
    typedef enum logic [1:0] {
        NPC_SEL_SEQ = 2'b00,
        NPC_SEL_BR  = 2'b01,
        NPC_SEL_J   = 2'b10,
        NPC_SEL_REG = 2'b11
    } npc_sel_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEFAULT = 1024;

    // Instruction field bit ranges, shared with the decoder and stall unit.
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;
    localparam int IDX26_HI = 25;
    localparam int IDX26_LO = 0;

    function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Next-PC selection: sequential, taken branch, j/jal, register jump.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is loaded into the PC.
// Ports: pc_f/pc_d/ir_d/jr_data in, npc_sel/br_taken select, npc out.
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] ir_d,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] jr_data,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] imm_ext;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign seq_pc    = pc_f + 32'd4;
    assign imm_ext   = sext_imm16(ir_d[IMM16_HI:IMM16_LO]);
    // Branch and jump targets are relative to the instruction in D, not the
    // delay slot sitting in IF.
    assign br_target = pc_d + 32'd4 + {imm_ext[29:0], 2'b00};
    assign j_target  = {pc_d[31:28], ir_d[IDX26_HI:IDX26_LO], 2'b00};

    always_comb begin
        npc = seq_pc;
        case (npc_sel_e'(npc_sel))
            NPC_SEL_SEQ: npc = seq_pc;
            NPC_SEL_BR:  npc = br_taken ? br_target : seq_pc;
            NPC_SEL_J:   npc = j_target;
            NPC_SEL_REG: npc = jr_data;   // unaligned values pass through; IF flags them
            default:     npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC, ROM fetch address, instruction capture into D.
// Latency: instruction appears on IR_D one cycle after its address is on PC_F.
// Backpressure: PC_En=0 holds the PC, IF_ID_En=0 holds the D register; each honoured independently.
// Ports: clk/reset(async, low); PC_En/IF_ID_En stall enables; Instr_F ROM data;
//        NPC_Sel/Br_Taken/Jr_Data redirect from D; PC_F fetch address; IR_D/PC_D/PC8_D/AdEL_D to D.
module fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_En,
    input  logic        IF_ID_En,
    input  logic [31:0] Instr_F,
    input  logic [1:0]  NPC_Sel,
    input  logic        Br_Taken,
    input  logic [31:0] Jr_Data,
    output logic [31:0] PC_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        AdEL_D
);

    // Upper bound held at 33 bits so a ROM ending at 2^32 cannot wrap to zero.
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + (33'(IM_WORDS) * 33'd4);

    logic [31:0] npc;
    logic        legal;

    npc_calc u_npc_calc (
        .pc_f     (PC_F),
        .pc_d     (PC_D),
        .ir_d     (IR_D),
        .npc_sel  (NPC_Sel),
        .br_taken (Br_Taken),
        .jr_data  (Jr_Data),
        .npc      (npc)
    );

    assign legal = (PC_F[1:0] == 2'b00) && (PC_F >= PC_RESET) && ({1'b0, PC_F} < PC_LIMIT);
    assign PC8_D = PC_D + 32'd8;

    // Redirects never flush IF: the delay-slot instruction is captured normally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_F <= PC_RESET;
        end else if (PC_En) begin
            PC_F <= npc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IR_D   <= NOP;
            PC_D   <= 32'd0;
            AdEL_D <= 1'b0;
        end else if (IF_ID_En) begin
            IR_D   <= legal ? Instr_F : NOP;
            PC_D   <= PC_F;
            AdEL_D <= !legal;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        adel;
    } d_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_En;
    logic        IF_ID_En;
    logic [31:0] Instr_F;
    logic [1:0]  NPC_Sel;
    logic        Br_Taken;
    logic [31:0] Jr_Data;
    logic [31:0] PC_F;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        AdEL_D;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_pc;
    d_t          sb_q[$];
    d_t          exp_d;
    d_t          got_d;
    d_t          held_d;
    int          checks = 0;
    int          passes = 0;

    fetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .PC_En    (PC_En),
        .IF_ID_En (IF_ID_En),
        .Instr_F  (Instr_F),
        .NPC_Sel  (NPC_Sel),
        .Br_Taken (Br_Taken),
        .Jr_Data  (Jr_Data),
        .PC_F     (PC_F),
        .IR_D     (IR_D),
        .PC_D     (PC_D),
        .PC8_D    (PC8_D),
        .AdEL_D   (AdEL_D)
    );

    always #5 clk = ~clk;

    // Combinational ROM covering 0x3000..0x3FFF; outside it returns junk.
    assign Instr_F = (PC_F >= 32'h3000 && PC_F < 32'h4000) ? mem[PC_F[11:2]] : 32'hDEAD_BEEF;

    function automatic logic bench_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a < 32'h4000);
    endfunction

    function automatic logic [31:0] bench_rom(input logic [31:0] a);
        if (a >= 32'h3000 && a < 32'h4000) return mem[a[11:2]];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock with the given enables; pushes the D contents the bench expects
    // and advances the bench PC to npc_exp when the PC is enabled.
    task automatic step(input logic pen, input logic ien, input logic [31:0] npc_exp);
        PC_En    = pen;
        IF_ID_En = ien;
        if (ien)
            sb_q.push_back('{ir:   bench_legal(exp_pc) ? bench_rom(exp_pc) : 32'h0,
                             pc:   exp_pc,
                             adel: !bench_legal(exp_pc)});
        @(posedge clk);
        #1;
        if (pen) exp_pc = npc_exp;
    endtask

    task automatic test_reset;
        reset = 1'b0; PC_En = 1'b1; IF_ID_En = 1'b1;
        NPC_Sel = 2'b00; Br_Taken = 1'b0; Jr_Data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({PC_F, IR_D, PC_D, AdEL_D, PC8_D} !== {32'h3000, 32'h0, 32'h0, 1'b0, 32'h8})
            $display("FAIL reset_state: got pc_f=%h ir=%h pc_d=%h adel=%b pc8=%h want 3000/0/0/0/8",
                     PC_F, IR_D, PC_D, AdEL_D, PC8_D);
        else passes++;
        reset  = 1'b1;
        exp_pc = 32'h3000;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, exp_pc + 32'd4);
            exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
            checks++;
            if (got_d !== exp_d) $display("FAIL reset_fetch%0d: got %h want %h", i, got_d, exp_d);
            else passes++;
        end
        checks++;
        if (PC_F !== 32'h3008) $display("FAIL reset_pc_after2: got %h want 00003008", PC_F);
        else passes++;
    endtask

    task automatic test_seq_stall;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, exp_pc + 32'd4);
            exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
            checks++;
            if (got_d !== exp_d) $display("FAIL seq_fetch%0d: got %h want %h", i, got_d, exp_d);
            else passes++;
        end
        held_d = exp_d;
        NPC_Sel = 2'b10;   // a jump in D must not move a stalled PC
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        NPC_Sel = 2'b00;
        checks++;
        if ({PC_F, IR_D, PC_D, AdEL_D} !== {32'h3010, held_d})
            $display("FAIL stall_hold: got pc_f=%h ir=%h pc_d=%h want pc_f=00003010 d=%h",
                     PC_F, IR_D, PC_D, held_d);
        else passes++;
        checks++;
        if (held_d.pc !== 32'h300C) $display("FAIL stall_pcd: got %h want 0000300c", held_d.pc);
        else passes++;
        step(1'b1, 1'b1, exp_pc + 32'd4);
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (PC_F !== 32'h3014 || got_d !== exp_d)
            $display("FAIL stall_resume: got pc_f=%h d=%h want 00003014 d=%h", PC_F, got_d, exp_d);
        else passes++;
    endtask

    task automatic test_independent;
        held_d = '{IR_D, PC_D, AdEL_D};
        step(1'b1, 1'b0, exp_pc + 32'd4);
        checks++;
        if (PC_F !== 32'h3018 || {IR_D, PC_D, AdEL_D} !== held_d)
            $display("FAIL pc_only: got pc_f=%h d=%h want 00003018 d=%h", PC_F, {IR_D, PC_D, AdEL_D}, held_d);
        else passes++;
        step(1'b0, 1'b1, 32'h0);
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (PC_F !== 32'h3018 || got_d !== exp_d)
            $display("FAIL ifid_only: got pc_f=%h d=%h want 00003018 d=%h", PC_F, got_d, exp_d);
        else passes++;
    endtask

    task automatic test_branch;
        // Walk to PC_F=0x3024 so the beq at 0x3020 sits in D.
        while (exp_pc != 32'h3024) begin
            step(1'b1, 1'b1, exp_pc + 32'd4);
            exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
            checks++;
            if (got_d !== exp_d) $display("FAIL walk_%h: got %h want %h", got_d.pc, got_d, exp_d);
            else passes++;
        end
        NPC_Sel = 2'b01; Br_Taken = 1'b1;
        step(1'b1, 1'b1, 32'h301C);
        NPC_Sel = 2'b00; Br_Taken = 1'b0;
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (PC_F !== 32'h301C) $display("FAIL beq_taken_pc: got %h want 0000301c", PC_F);
        else passes++;
        checks++;
        if (got_d !== exp_d || got_d.pc !== 32'h3024)
            $display("FAIL beq_delay_slot: got %h want %h", got_d, exp_d);
        else passes++;
        step(1'b1, 1'b1, exp_pc + 32'd4);
        step(1'b1, 1'b1, exp_pc + 32'd4);
        void'(sb_q.pop_front());
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (got_d !== exp_d || IR_D !== 32'h1000_FFFE)
            $display("FAIL beq_back_in_d: got %h want %h", got_d, exp_d);
        else passes++;
        NPC_Sel = 2'b01; Br_Taken = 1'b0;
        step(1'b1, 1'b1, 32'h3028);
        NPC_Sel = 2'b00;
        void'(sb_q.pop_front());
        checks++;
        if (PC_F !== 32'h3028) $display("FAIL beq_not_taken: got %h want 00003028", PC_F);
        else passes++;
    endtask

    task automatic test_jal_jr;
        NPC_Sel = 2'b11; Jr_Data = 32'h3000;
        step(1'b1, 1'b1, 32'h3000);
        NPC_Sel = 2'b00;
        step(1'b1, 1'b1, 32'h3004);
        void'(sb_q.pop_front());
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (got_d !== exp_d || PC8_D !== 32'h3008)
            $display("FAIL jal_in_d: got d=%h pc8=%h want d=%h pc8=00003008", got_d, PC8_D, exp_d);
        else passes++;
        NPC_Sel = 2'b10;
        step(1'b1, 1'b1, 32'h3040);
        void'(sb_q.pop_front());
        checks++;
        if (PC_F !== 32'h3040) $display("FAIL jal_target: got %h want 00003040", PC_F);
        else passes++;
        NPC_Sel = 2'b11; Jr_Data = 32'h3008;
        step(1'b1, 1'b1, 32'h3008);
        NPC_Sel = 2'b00;
        void'(sb_q.pop_front());
        checks++;
        if (PC_F !== 32'h3008) $display("FAIL jr_target: got %h want 00003008", PC_F);
        else passes++;
    endtask

    task automatic test_illegal;
        logic [31:0] tgts [4];
        logic [31:0] wants[4];
        tgts  = '{32'h3002, 32'h3FFC, 32'h2FFC, 32'hFFFF_FFFC};
        wants = '{32'h3006, 32'h4000, 32'h3000, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            NPC_Sel = 2'b11; Jr_Data = tgts[i];
            step(1'b1, 1'b1, tgts[i]);
            NPC_Sel = 2'b00;
            void'(sb_q.pop_front());
            step(1'b1, 1'b1, exp_pc + 32'd4);
            exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
            checks++;
            if (got_d !== exp_d || PC_F !== wants[i])
                $display("FAIL fetch_at_%h: got d=%h pc_f=%h want d=%h pc_f=%h",
                         tgts[i], got_d, PC_F, exp_d, wants[i]);
            else passes++;
        end
        // 0x3FFC was legal; the fetch at 0x4000 must be flagged.
        step(1'b1, 1'b1, exp_pc + 32'd4);
        exp_d = sb_q.pop_front();
        NPC_Sel = 2'b11; Jr_Data = 32'h3FFC;
        step(1'b1, 1'b1, 32'h3FFC);
        NPC_Sel = 2'b00;
        void'(sb_q.pop_front());
        step(1'b1, 1'b1, 32'h4000);
        void'(sb_q.pop_front());
        step(1'b1, 1'b1, 32'h4004);
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (got_d !== {32'h0, 32'h4000, 1'b1})
            $display("FAIL adel_at_4000: got %h want 00000000_00004000_1", got_d);
        else passes++;
    endtask

    task automatic test_async_reset;
        NPC_Sel = 2'b10; PC_En = 1'b0; IF_ID_En = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({PC_F, IR_D, PC_D, AdEL_D} !== {32'h3000, 32'h0, 32'h0, 1'b0})
            $display("FAIL async_reset: got pc_f=%h ir=%h pc_d=%h adel=%b want 3000/0/0/0",
                     PC_F, IR_D, PC_D, AdEL_D);
        else passes++;
        @(posedge clk); #1;
        NPC_Sel = 2'b00;
        reset   = 1'b1;
        exp_pc  = 32'h3000;
        sb_q.delete();
        step(1'b1, 1'b1, 32'h3004);
        exp_d = sb_q.pop_front(); got_d = '{IR_D, PC_D, AdEL_D};
        checks++;
        if (got_d !== exp_d || got_d.pc !== 32'h3000 || PC_F !== 32'h3004)
            $display("FAIL post_reset_fetch: got d=%h pc_f=%h want d=%h pc_f=00003004", got_d, PC_F, exp_d);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0C00_0C10;   // jal index 0x0000C10
        mem[8] = 32'h1000_FFFE;   // beq at 0x3020, imm -2
        test_reset();
        test_seq_stall();
        test_independent();
        test_branch();
        test_jal_jr();
        test_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

endmodule
